// File: rtl/ahb_sram16.sv
// ahb_sram16: AHB-Lite slave mapping a 512K x 16 asynchronous SRAM as 1 MB of byte-addressable
// memory. Each AHB data phase becomes one (byte/halfword) or two (word) timed SRAM halfword cycles.
// Optional build macro AHB_SRAM_ALIGN_ERR_EN: misaligned transfers get a two-cycle ERROR response
// instead of being aligned down.
module ahb_sram16 #(
  parameter int unsigned ACC_CYC = 2  // HCLK cycles nOE/nWE held low per access, 1..15
) (
  input  logic        HCLK,
  input  logic        HRESET,
  input  logic        HSEL,
  input  logic [19:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  output logic [18:0] SRAM_ADDR,
  output logic [15:0] SRAM_DQ_O,
  output logic        SRAM_DQ_OE,
  input  logic [15:0] SRAM_DQ_I,
  output logic        SRAM_nCE,
  output logic        SRAM_nOE,
  output logic        SRAM_nWE,
  output logic        SRAM_nLB,
  output logic        SRAM_nUB
);

  typedef enum logic [2:0] {
    StIdle, StRdAcc, StDone, StWrSetup, StWrStb, StWrHold, StErr1, StErr2
  } state_e;

  localparam logic [3:0] CntLoad = 4'(ACC_CYC - 1);

  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        word_q, word_d;      // current transfer needs two halfword accesses
  logic        hi_q, hi_d;          // working on the high half of a word
  logic        wsel_q, wsel_d;      // byte/halfword write takes HWDATA[31:16]
  logic        lb_q, lb_d;          // registered active-low lane enables for this transfer
  logic        ub_q, ub_d;
  logic [18:0] addr_q, addr_d;
  logic [31:0] hrdata_q, hrdata_d;
  logic [15:0] dq_q, dq_d;
  logic [15:0] wdata_hi_q, wdata_hi_d;
  logic        nce_q, noe_q, nwe_q, nlb_q, nub_q, dqoe_q;

  logic        hready_out;
  logic        start;
  logic        new_word;
  logic        new_byte;
  logic        misalign;
  logic        access_d;
  logic [15:0] dq_drive;
  logic        unused_htrans;

  assign unused_htrans = HTRANS[0];
  assign new_word      = (HSIZE[2:1] != 2'b00);
  assign new_byte      = (HSIZE == 3'b000);

`ifdef AHB_SRAM_ALIGN_ERR_EN
  assign misalign = ((HSIZE == 3'b001) && HADDR[0]) || (new_word && (HADDR[1:0] != 2'b00));
`else
  assign misalign = 1'b0;
`endif

  // Slave ready: idle, read completion, final write hold and second error cycle.
  always_comb begin
    hready_out = 1'b0;
    case (state_q)
      StIdle, StDone, StErr2: hready_out = 1'b1;
      StWrHold:               hready_out = ~(word_q & ~hi_q);
      default:                hready_out = 1'b0;
    endcase
  end

  assign start = HSEL & HREADY & HTRANS[1] & hready_out;

  // Write data: the first data-phase cycle drives HWDATA live, later cycles use the latch.
  always_comb begin
    dq_drive = dq_q;
    if (state_q == StWrSetup && !hi_q) begin
      dq_drive = wsel_q ? HWDATA[31:16] : HWDATA[15:0];
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    word_d     = word_q;
    hi_d       = hi_q;
    wsel_d     = wsel_q;
    lb_d       = lb_q;
    ub_d       = ub_q;
    addr_d     = addr_q;
    hrdata_d   = hrdata_q;
    dq_d       = dq_q;
    wdata_hi_d = wdata_hi_q;

    case (state_q)
      StIdle: state_d = StIdle;
      StDone, StErr2: state_d = StIdle;
      StRdAcc: begin
        if (cnt_q == 4'd0) begin
          if (word_q && !hi_q) begin
            hrdata_d[15:0] = SRAM_DQ_I;
            hi_d           = 1'b1;
            addr_d[0]      = 1'b1;
            cnt_d          = CntLoad;
          end else begin
            if (word_q) begin
              hrdata_d[31:16] = SRAM_DQ_I;
            end else begin
              hrdata_d = {SRAM_DQ_I, SRAM_DQ_I};
            end
            state_d = StDone;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrSetup: begin
        state_d = StWrStb;
        cnt_d   = CntLoad;
        dq_d    = dq_drive;
        if (!hi_q) begin
          wdata_hi_d = HWDATA[31:16];
        end
      end
      StWrStb: begin
        if (cnt_q == 4'd0) begin
          state_d = StWrHold;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      StWrHold: begin
        if (word_q && !hi_q) begin
          state_d   = StWrSetup;
          hi_d      = 1'b1;
          addr_d[0] = 1'b1;
          dq_d      = wdata_hi_q;
        end else begin
          state_d = StIdle;
        end
      end
      StErr1: state_d = StErr2;
      default: state_d = StIdle;
    endcase

    // A new address phase is only seen in ready states, so it overrides the above.
    if (start) begin
      if (misalign) begin
        state_d = StErr1;
      end else begin
        state_d = HWRITE ? StWrSetup : StRdAcc;
        cnt_d   = CntLoad;
        word_d  = new_word;
        hi_d    = 1'b0;
        wsel_d  = HADDR[1] & ~new_word;
        lb_d    = new_byte ? HADDR[0] : 1'b0;
        ub_d    = new_byte ? ~HADDR[0] : 1'b0;
        addr_d  = new_word ? {HADDR[19:2], 1'b0} : HADDR[19:1];
      end
    end
  end

  assign access_d = (state_d == StRdAcc) || (state_d == StWrSetup) ||
                    (state_d == StWrStb) || (state_d == StWrHold);

  // State, datapath and glitch-free registered SRAM strobes.
  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q    <= StIdle;
      cnt_q      <= 4'd0;
      word_q     <= 1'b0;
      hi_q       <= 1'b0;
      wsel_q     <= 1'b0;
      lb_q       <= 1'b1;
      ub_q       <= 1'b1;
      addr_q     <= 19'd0;
      hrdata_q   <= 32'd0;
      dq_q       <= 16'd0;
      wdata_hi_q <= 16'd0;
      nce_q      <= 1'b1;
      noe_q      <= 1'b1;
      nwe_q      <= 1'b1;
      nlb_q      <= 1'b1;
      nub_q      <= 1'b1;
      dqoe_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      word_q     <= word_d;
      hi_q       <= hi_d;
      wsel_q     <= wsel_d;
      lb_q       <= lb_d;
      ub_q       <= ub_d;
      addr_q     <= addr_d;
      hrdata_q   <= hrdata_d;
      dq_q       <= dq_d;
      wdata_hi_q <= wdata_hi_d;
      nce_q      <= ~access_d;
      noe_q      <= ~(state_d == StRdAcc);
      nwe_q      <= ~(state_d == StWrStb);
      nlb_q      <= access_d ? lb_d : 1'b1;
      nub_q      <= access_d ? ub_d : 1'b1;
      dqoe_q     <= (state_d == StWrSetup) || (state_d == StWrStb) || (state_d == StWrHold);
    end
  end

  assign HREADYOUT  = hready_out;
  assign HRESP      = (state_q == StErr1) || (state_q == StErr2);
  assign HRDATA     = hrdata_q;
  assign SRAM_ADDR  = addr_q;
  assign SRAM_DQ_O  = dq_drive;
  assign SRAM_DQ_OE = dqoe_q;
  assign SRAM_nCE   = nce_q;
  assign SRAM_nOE   = noe_q;
  assign SRAM_nWE   = nwe_q;
  assign SRAM_nLB   = nlb_q;
  assign SRAM_nUB   = nub_q;

endmodule

// File: tb/tb_ahb_sram16.sv
// tb_ahb_sram16: self-checking bench for ahb_sram16 with a behavioural SRAM and a byte-level
// reference memory. Honours AHB_SRAM_ALIGN_ERR_EN when defined.
module tb_ahb_sram16;
  localparam int unsigned AccCyc = 2;

  typedef struct {
    logic [18:0] addr;
    logic [15:0] data;
    logic        nlb;
    logic        nub;
    logic        oe;
  } wev_t;

  logic        clk = 1'b0;
  logic        hreset, hsel, hwrite, hready, hreadyout, hresp;
  logic [19:0] haddr;
  logic [1:0]  htrans;
  logic [2:0]  hsize;
  logic [31:0] hwdata, hrdata;
  logic [18:0] sram_addr;
  logic [15:0] dq_o, dq_i;
  logic        dq_oe, nce, noe, nwe, nlb, nub;

  logic [15:0] sram [0:524287];
  logic [7:0]  ref_mem [0:1048575];
  wev_t        wlog [$];
  logic [18:0] rlog [$];
  int          overlap_cnt = 0;
  int          nce_low_cnt = 0;
  int          n_checks = 0;
  int          n_fail = 0;
  logic        prev_noe = 1'b1;
  logic        prev_nwe = 1'b1;
  logic [18:0] prev_addr = '0;

  always #5 clk = ~clk;

  assign hready = hreadyout;
  assign dq_i   = (!nce && !noe) ? sram[sram_addr] : 16'hDEAD;

  ahb_sram16 #(.ACC_CYC(AccCyc)) dut (
    .HCLK(clk), .HRESET(hreset), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans), .HSIZE(hsize),
    .HWRITE(hwrite), .HWDATA(hwdata), .HREADY(hready), .HREADYOUT(hreadyout), .HRDATA(hrdata),
    .HRESP(hresp), .SRAM_ADDR(sram_addr), .SRAM_DQ_O(dq_o), .SRAM_DQ_OE(dq_oe),
    .SRAM_DQ_I(dq_i), .SRAM_nCE(nce), .SRAM_nOE(noe), .SRAM_nWE(nwe), .SRAM_nLB(nlb),
    .SRAM_nUB(nub)
  );

  // Behavioural SRAM plus access logging, sampled mid-cycle.
  always @(negedge clk) begin
    if (!noe && !nwe) overlap_cnt++;
    if (!nce) nce_low_cnt++;
    if (!nce && !nwe) begin
      if (!nlb) sram[sram_addr][7:0] = dq_o[7:0];
      if (!nub) sram[sram_addr][15:8] = dq_o[15:8];
      if (prev_nwe) wlog.push_back('{sram_addr, dq_o, nlb, nub, dq_oe});
    end
    if (!nce && !noe && (prev_noe || sram_addr != prev_addr)) rlog.push_back(sram_addr);
    prev_noe  = noe;
    prev_nwe  = nwe;
    prev_addr = sram_addr;
  end

  // Reference: AHB byte semantics, byte lane k of HWDATA holds address (4n+k).
  function automatic int nbytes(input logic [2:0] sz);
    return (sz >= 3'd2) ? 4 : (1 << sz);
  endfunction

  function automatic void ref_wr(input logic [19:0] a, input logic [2:0] sz,
                                 input logic [31:0] wd);
    int n    = nbytes(sz);
    int base = int'(a) & ~(n - 1);
    for (int i = 0; i < n; i++) ref_mem[base + i] = wd[8 * ((base + i) % 4) +: 8];
  endfunction

  function automatic logic [31:0] ref_rd(input logic [19:0] a, input logic [2:0] sz);
    int          b;
    logic [15:0] h;
    if (nbytes(sz) == 4) begin
      b = int'(a) & ~3;
      return {ref_mem[b + 3], ref_mem[b + 2], ref_mem[b + 1], ref_mem[b]};
    end
    b = int'(a) & ~1;
    h = {ref_mem[b + 1], ref_mem[b]};
    return {h, h};
  endfunction

  // One non-pipelined transfer; cyc counts data-phase cycles including the ready one.
  task automatic ahb_xfer(input logic wr, input logic [19:0] a, input logic [2:0] sz,
                          input logic [31:0] wd, output logic [31:0] rd, output int cyc,
                          output logic resp);
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = a; hsize = sz; hwrite = wr;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = wd;
    cyc  = 0;
    resp = 1'b0;
    do begin
      @(negedge clk);
      cyc++;
      resp |= hresp;
    end while (!hreadyout && cyc < 200);
    rd = hrdata;
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    repeat (3) @(posedge clk);
    #1 hreset = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      n_checks++;
      if ({hreadyout, hresp, nce, noe, nwe, nlb, nub, dq_oe} !== 8'b1011_1110) begin
        n_fail++;
        $display("FAIL idle_outputs cyc%0d: got %b expected 10111110", i,
                 {hreadyout, hresp, nce, noe, nwe, nlb, nub, dq_oe});
      end
    end
    n_checks++;
    if ({hrdata, sram_addr, dq_o} !== '0) begin
      n_fail++;
      $display("FAIL reset_regs: got hrdata=%h addr=%h dq=%h expected zeros",
               hrdata, sram_addr, dq_o);
    end
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b00; haddr = 20'h10; hsize = 3'd2; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0;
    @(negedge clk);
    n_checks++;
    if ({hreadyout, hresp, nce} !== 3'b101 || wlog.size() + rlog.size() != 0) begin
      n_fail++;
      $display("FAIL idle_trans: got rdy/resp/nce=%b accesses=%0d expected 101 and 0",
               {hreadyout, hresp, nce}, wlog.size() + rlog.size());
    end
  endtask

  task automatic test_word_wr_rd();
    logic [31:0] rd;
    int          cyc;
    logic        resp;
    int          w0 = wlog.size();
    int          r0 = rlog.size();
    ahb_xfer(1'b1, 20'h00010, 3'd2, 32'hCAFE1234, rd, cyc, resp);
    ref_wr(20'h00010, 3'd2, 32'hCAFE1234);
    n_checks++;
    if (cyc != 2 * (AccCyc + 2) || resp !== 1'b0) begin
      n_fail++;
      $display("FAIL word_wr_len: got %0d resp=%b expected %0d resp=0", cyc, resp,
               2 * (AccCyc + 2));
    end
    n_checks++;
    if (wlog.size() - w0 != 2) begin
      n_fail++;
      $display("FAIL word_wr_count: got %0d expected 2", wlog.size() - w0);
    end else begin
      n_checks++;
      if (wlog[w0].addr !== 19'h8 || wlog[w0].data !== 16'h1234 || wlog[w0 + 1].addr !== 19'h9 ||
          wlog[w0 + 1].data !== 16'hCAFE || {wlog[w0].nlb, wlog[w0].nub, wlog[w0].oe} !== 3'b001) begin
        n_fail++;
        $display("FAIL word_wr_sram: got %h:%h %h:%h expected 00008:1234 00009:cafe",
                 wlog[w0].addr, wlog[w0].data, wlog[w0 + 1].addr, wlog[w0 + 1].data);
      end
    end
    ahb_xfer(1'b0, 20'h00010, 3'd2, 32'h0, rd, cyc, resp);
    n_checks++;
    if (cyc != 2 * AccCyc + 1 || rd !== 32'hCAFE1234) begin
      n_fail++;
      $display("FAIL word_rd: got len=%0d data=%h expected len=%0d data=cafe1234", cyc, rd,
               2 * AccCyc + 1);
    end
    n_checks++;
    if (rlog.size() - r0 != 2 || rlog[r0] !== 19'h8 || rlog[rlog.size() - 1] !== 19'h9) begin
      n_fail++;
      $display("FAIL word_rd_addrs: got %0d accesses expected 00008,00009", rlog.size() - r0);
    end
  endtask

  task automatic test_byte_lanes();
    logic [31:0] rd;
    int          cyc;
    logic        resp;
    int          w0 = wlog.size();
    ahb_xfer(1'b1, 20'h00003, 3'd0, 32'hAB000000, rd, cyc, resp);
    ref_wr(20'h00003, 3'd0, 32'hAB000000);
    n_checks++;
    if (cyc != AccCyc + 2 || wlog.size() - w0 != 1) begin
      n_fail++;
      $display("FAIL byte_wr_len: got len=%0d accesses=%0d expected %0d and 1", cyc,
               wlog.size() - w0, AccCyc + 2);
    end else begin
      n_checks++;
      if (wlog[w0].addr !== 19'h1 || wlog[w0].data[15:8] !== 8'hAB ||
          {wlog[w0].nlb, wlog[w0].nub} !== 2'b10) begin
        n_fail++;
        $display("FAIL byte_wr_lanes: got addr=%h dq=%h nlb/nub=%b expected 00001 ab.. 10",
                 wlog[w0].addr, wlog[w0].data, {wlog[w0].nlb, wlog[w0].nub});
      end
    end
    ahb_xfer(1'b0, 20'h00002, 3'd1, 32'h0, rd, cyc, resp);
    n_checks++;
    if (rd[31:24] !== 8'hAB || rd !== ref_rd(20'h00002, 3'd1) || cyc != AccCyc + 1) begin
      n_fail++;
      $display("FAIL half_rd: got %h len=%0d expected %h len=%0d", rd, cyc,
               ref_rd(20'h00002, 3'd1), AccCyc + 1);
    end
  endtask

  task automatic test_back_to_back();
    int cyc = 0;
    int w0  = wlog.size();
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 20'h00040; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    hwdata = 32'h5EED_F00D;
    hwrite = 1'b0;  // read address phase for the same word, held until accepted
    do begin @(negedge clk); cyc++; end while (!hreadyout && cyc < 200);
    ref_wr(20'h00040, 3'd2, 32'h5EED_F00D);
    n_checks++;
    if (cyc != 2 * (AccCyc + 2) || wlog.size() - w0 != 2) begin
      n_fail++;
      $display("FAIL b2b_wr: got len=%0d accesses=%0d expected %0d and 2", cyc,
               wlog.size() - w0, 2 * (AccCyc + 2));
    end
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({nce, noe, nwe} !== 3'b001 || sram_addr !== 19'h20) begin
      n_fail++;
      $display("FAIL b2b_rd_start: got nce/noe/nwe=%b addr=%h expected 001 00020",
               {nce, noe, nwe}, sram_addr);
    end
    cyc = 1;
    while (!hreadyout && cyc < 200) begin @(negedge clk); cyc++; end
    n_checks++;
    if (cyc != 2 * AccCyc + 1 || hrdata !== 32'h5EED_F00D) begin
      n_fail++;
      $display("FAIL b2b_rd: got len=%0d data=%h expected %0d 5eedf00d", cyc, hrdata,
               2 * AccCyc + 1);
    end
  endtask

  task automatic test_reset_mid_write();
    int w0;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 20'h40000; hsize = 3'd2; hwrite = 1'b1;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00; hwdata = 32'hBEEF_C0DE;
    @(posedge clk); #1;
    hreset = 1'b1;  // now in the first strobe cycle of the low half
    @(posedge clk); #1;
    hreset = 1'b0;
    w0 = wlog.size();
    @(negedge clk);
    n_checks++;
    if ({nwe, dq_oe, hreadyout, nce} !== 4'b1011) begin
      n_fail++;
      $display("FAIL reset_mid_wr: got nwe/oe/rdy/nce=%b expected 1011",
               {nwe, dq_oe, hreadyout, nce});
    end
    repeat (10) @(negedge clk);
    n_checks++;
    if (sram[19'h20001] !== 16'h0000 || wlog.size() != w0) begin
      n_fail++;
      $display("FAIL reset_no_hi: got hi=%h late writes=%0d expected 0000 and 0",
               sram[19'h20001], wlog.size() - w0);
    end
  endtask

  task automatic test_align();
`ifdef AHB_SRAM_ALIGN_ERR_EN
    int c0 = nce_low_cnt;
    @(posedge clk); #1;
    hsel = 1'b1; htrans = 2'b10; haddr = 20'h00002; hsize = 3'd2; hwrite = 1'b0;
    @(posedge clk); #1;
    hsel = 1'b0; htrans = 2'b00;
    @(negedge clk);
    n_checks++;
    if ({hreadyout, hresp} !== 2'b01) begin
      n_fail++;
      $display("FAIL err_cyc1: got rdy/resp=%b expected 01", {hreadyout, hresp});
    end
    @(negedge clk);
    n_checks++;
    if ({hreadyout, hresp} !== 2'b11) begin
      n_fail++;
      $display("FAIL err_cyc2: got rdy/resp=%b expected 11", {hreadyout, hresp});
    end
    @(negedge clk);
    n_checks++;
    if (nce_low_cnt != c0 || hresp !== 1'b0) begin
      n_fail++;
      $display("FAIL err_no_sram: got nce-low cycles=%0d resp=%b expected 0 and 0",
               nce_low_cnt - c0, hresp);
    end
`else
    logic [31:0] rd;
    int          cyc;
    logic        resp;
    int          r0 = rlog.size();
    ahb_xfer(1'b0, 20'h00002, 3'd2, 32'h0, rd, cyc, resp);
    n_checks++;
    if (resp !== 1'b0 || cyc != 2 * AccCyc + 1 || rd !== ref_rd(20'h00000, 3'd2)) begin
      n_fail++;
      $display("FAIL misalign_rd: got resp=%b len=%0d data=%h expected 0 %0d %h", resp, cyc,
               rd, 2 * AccCyc + 1, ref_rd(20'h00000, 3'd2));
    end
    n_checks++;
    if (rlog.size() - r0 != 2 || rlog[r0] !== 19'h0 || rlog[rlog.size() - 1] !== 19'h1) begin
      n_fail++;
      $display("FAIL misalign_addrs: got %0d accesses expected 00000,00001", rlog.size() - r0);
    end
`endif
  endtask

  task automatic test_random();
    logic [31:0] rd, wd;
    logic [19:0] a;
    logic [2:0]  sz;
    logic        wr, resp;
    int          cyc, exp_cyc, w0, n;
    for (int i = 0; i < 80; i++) begin
      wr = 1'(($urandom % 3) != 0);
      sz = 3'($urandom_range(0, 2));
      n  = nbytes(sz);
      a  = 20'($urandom_range(0, 1023) & ~(n - 1));
      wd = $urandom;
      w0 = wlog.size();
      ahb_xfer(wr, a, sz, wd, rd, cyc, resp);
      if (wr) begin
        ref_wr(a, sz, wd);
        exp_cyc = (n == 4) ? 2 * (AccCyc + 2) : AccCyc + 2;
        n_checks++;
        if (cyc != exp_cyc || resp !== 1'b0 || wlog.size() - w0 != ((n == 4) ? 2 : 1)) begin
          n_fail++;
          $display("FAIL rand_wr%0d a=%h sz=%0d: got len=%0d acc=%0d expected len=%0d", i, a,
                   sz, cyc, wlog.size() - w0, exp_cyc);
        end
      end else begin
        exp_cyc = (n == 4) ? 2 * AccCyc + 1 : AccCyc + 1;
        n_checks++;
        if (cyc != exp_cyc || resp !== 1'b0 || rd !== ref_rd(a, sz)) begin
          n_fail++;
          $display("FAIL rand_rd%0d a=%h sz=%0d: got %h len=%0d expected %h len=%0d", i, a,
                   sz, rd, cyc, ref_rd(a, sz), exp_cyc);
        end
      end
    end
  endtask

  initial begin
    hreset = 1'b1; hsel = 1'b0; htrans = 2'b00; haddr = '0; hsize = '0; hwrite = 1'b0;
    hwdata = '0;
    for (int i = 0; i < 524288; i++) sram[i] = 16'h0000;
    for (int i = 0; i < 1048576; i++) ref_mem[i] = 8'h00;
    test_reset();
    test_word_wr_rd();
    test_byte_lanes();
    test_back_to_back();
    test_reset_mid_write();
    test_align();
    test_random();
    n_checks++;
    if (overlap_cnt != 0) begin
      n_fail++;
      $display("FAIL noe_nwe_overlap: got %0d cycles expected 0", overlap_cnt);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ahb_sram16.md
Name: ahb_sram16

Overview:
- AHB-Lite slave that maps the board's 512K x 16 asynchronous SRAM into CM3 address space as 1 MB of byte-addressable memory.
- Connects to a spare TARGEXP port of the CM3 core at the same level as the UART and 7-segment slaves, and takes over the SRAM pins that are currently tied inactive.
- Turns each AHB data phase into one or two timed SRAM halfword cycles.
- Top level builds the SRAM_DQ tristate from the DQ_O, DQ_OE and DQ_I ports.

Parameters:
- ACC_CYC, 2, HCLK cycles nOE/nWE held low per SRAM access; legal range 1..15.

Ports:
- HCLK  in  1  bus and block clock (the 100 MHz CM3 clock).
- HRESET  in  1  synchronous, active-high reset.
- HSEL  in  1  slave select.
- HADDR  in  20  byte address within the 1 MB window.
- HTRANS  in  2  transfer type.
- HSIZE  in  3  transfer size.
- HWRITE  in  1  1 = write.
- HWDATA  in  32  write data.
- HREADY  in  1  bus ready (READYMUX).
- HREADYOUT  out  1  slave ready.
- HRDATA  out  32  read data.
- HRESP  out  1  1 = ERROR.
- SRAM_ADDR  out  19  halfword address.
- SRAM_DQ_O  out  16  write data to pad.
- SRAM_DQ_OE  out  1  1 = drive pad.
- SRAM_DQ_I  in  16  read data from pad.
- SRAM_nCE  out  1  chip enable, active low.
- SRAM_nOE  out  1  output enable, active low.
- SRAM_nWE  out  1  write enable, active low.
- SRAM_nLB  out  1  low byte enable, active low.
- SRAM_nUB  out  1  high byte enable, active low.

Behaviour:
- Clock and reset: one clock, HCLK. Reset is HRESET, synchronous and active-high.
- Reset values: HREADYOUT=1, HRESP=0, HRDATA=0, SRAM_ADDR=0, SRAM_DQ_O=0, SRAM_DQ_OE=0, all SRAM strobes =1, state IDLE.
- Reset asserted mid-transfer: all strobes deassert and DQ_OE drops in the cycle reset is sampled; no partial halfword completes afterwards.
- Transfer start: a transfer starts when HSEL & HREADY & HTRANS[1] in a cycle where HREADYOUT=1.
  - HADDR, HSIZE and HWRITE are registered at that point.
  - IDLE or BUSY transfers, or HSEL=0, get a zero-wait OKAY and no SRAM activity.
- Access count:
  - Byte and halfword transfers use 1 SRAM access at HADDR[19:1].
  - Word transfers (HSIZE>=2) use 2 accesses: {HADDR[19:2],0} for the low half first, then {HADDR[19:2],1} for the high half.
- Byte lanes:
  - Halfword and word: nLB=nUB=0.
  - Byte: nLB=HADDR[0], nUB=~HADDR[0].
- State machine: IDLE -> RD_ACC or WR_SETUP; RD_ACC -> RD_ACC (high half) or DONE; WR_SETUP -> WR_STB -> WR_HOLD -> WR_SETUP (high half) or IDLE.
- Read accesses (RD_ACC, ACC_CYC cycles):
  - nCE=0 and nOE=0; DQ_OE=0.
  - SRAM_DQ_I is sampled on the last cycle of each access.
  - HRDATA: word = {hi,lo}; halfword/byte = {d,d}, so every AHB byte lane is correct.
  - Next cycle (DONE): HREADYOUT=1 with HRDATA valid.
  - Data-phase wait cycles: ACC_CYC+1 for halfword/byte, 2*ACC_CYC+1 for word.
- Write accesses:
  - WR_SETUP (1 cycle): address and data driven, DQ_OE=1, nCE=0, nWE=1.
  - WR_STB (ACC_CYC cycles): nWE=0.
  - WR_HOLD (1 cycle): nWE=1, address, data and DQ_OE held.
  - HREADYOUT=1 in the final WR_HOLD cycle.
  - Data phase length: ACC_CYC+2 cycles for halfword/byte, 2*(ACC_CYC+2) for word.
- Write data source:
  - Word: low half HWDATA[15:0], high half HWDATA[31:16].
  - Halfword/byte: HWDATA[31:16] if HADDR[1] else HWDATA[15:0].
  - HWDATA is sampled in the first data-phase cycle; AHB holds it stable.
- Back-to-back: an address phase arriving in the HREADYOUT=1 cycle is accepted, and its SRAM access begins the next cycle. nOE and nWE are never low simultaneously.
- Between transfers SRAM_ADDR holds its last value.

Optional Feature:
- AHB_SRAM_ALIGN_ERR_EN defined:
  - A misaligned transfer returns a two-cycle ERROR with no SRAM strobes.
  - Misaligned means halfword with HADDR[0]=1, or word with HADDR[1:0]!=0.
  - Cycle 1: HREADYOUT=0, HRESP=1. Cycle 2: HREADYOUT=1, HRESP=1.
- Undefined: the misaligned low address bits are ignored (address aligned down) and HRESP stays 0.

Test Plan:
- Reset then idle: no transfers for 20 cycles -> HREADYOUT=1, HRESP=0, all strobes 1, DQ_OE=0; HTRANS=IDLE with HSEL=1 -> zero-wait OKAY.
- Word write 0xCAFE1234 to 0x00010, then word read from 0x00010 (ACC_CYC=2):
  - write: SRAM writes 0x1234 at 0x00008 then 0xCAFE at 0x00009; data phase 8 cycles.
  - read: HRDATA=0xCAFE1234 after 5 wait-inclusive cycles.
- Byte write 0xAB to 0x00003 (HWDATA=0xAB000000) -> one access at 0x00001, nUB=0, nLB=1, DQ_O[15:8]=0xAB; halfword read of 0x00002 -> HRDATA[31:24]=0xAB.
- Back-to-back: write then read pipelined with no IDLE between -> second access starts the cycle after the first HREADYOUT=1; nOE and nWE never overlap.
- HRESET pulsed during WR_STB of a word write -> nWE=1, DQ_OE=0, HREADYOUT=1 the next cycle; the high half is never written.
- With AHB_SRAM_ALIGN_ERR_EN, word read at 0x00002 -> HRESP=1 for 2 cycles, HREADYOUT 0 then 1, nCE stays 1.
- Without AHB_SRAM_ALIGN_ERR_EN, the same read -> OKAY, reads SRAM addresses 0x00000 and 0x00001.
